// File: rtl/jtframe_cen24.sv
// Clock-enable generator for a 24 MHz system clock: 12/8/6/4/3/1.5 MHz enables plus 3 MHz quadrature.
// Define JTFRAME_CEN24_SHIFTED_EN to also generate the 180-degree-shifted enables (*b outputs).
module jtframe_cen24 (
  input  logic clk,
  input  logic rst,
  output logic cen12,
  output logic cen8,
  output logic cen6,
  output logic cen4,
  output logic cen3,
  output logic cen3q,
  output logic cen1p5,
  output logic cen12b,
  output logic cen6b,
  output logic cen3b,
  output logic cen3qb,
  output logic cen1p5b
);

  logic [3:0] r_cnt;
  logic [1:0] r_cnt3;
  logic       w_cnt3_top;

  // r_cnt and r_cnt3 hold the phase of the edge being processed, so each
  // output registered on this edge reflects that same phase.
  assign w_cnt3_top = (r_cnt3 == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 4'd0;
      r_cnt3 <= 2'd0;
    end else begin
      r_cnt  <= r_cnt + 4'd1;
      r_cnt3 <= w_cnt3_top ? 2'd0 : r_cnt3 + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cen12  <= 1'b0;
      cen8   <= 1'b0;
      cen6   <= 1'b0;
      cen4   <= 1'b0;
      cen3   <= 1'b0;
      cen3q  <= 1'b0;
      cen1p5 <= 1'b0;
    end else begin
      cen12  <= r_cnt[0];
      cen6   <= (r_cnt[1:0] == 2'd3);
      cen3   <= (r_cnt[2:0] == 3'd7);
      cen3q  <= (r_cnt[2:0] == 3'd5);
      cen1p5 <= (r_cnt == 4'd15);
      cen8   <= w_cnt3_top;
      cen4   <= w_cnt3_top & r_cnt[0];
    end
  end

`ifdef JTFRAME_CEN24_SHIFTED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cen12b  <= 1'b0;
      cen6b   <= 1'b0;
      cen3b   <= 1'b0;
      cen3qb  <= 1'b0;
      cen1p5b <= 1'b0;
    end else begin
      cen12b  <= ~r_cnt[0];
      cen6b   <= (r_cnt[1:0] == 2'd1);
      cen3b   <= (r_cnt[2:0] == 3'd3);
      cen3qb  <= (r_cnt[2:0] == 3'd1);
      cen1p5b <= (r_cnt == 4'd7);
    end
  end
`else
  assign cen12b  = 1'b0;
  assign cen6b   = 1'b0;
  assign cen3b   = 1'b0;
  assign cen3qb  = 1'b0;
  assign cen1p5b = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_cen24.sv
// Bench for jtframe_cen24: phase-counting reference model, pulse counts, mid-run and random resets.
module tb_jtframe_cen24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen12, cen8, cen6, cen4, cen3, cen3q, cen1p5;
  logic cen12b, cen6b, cen3b, cen3qb, cen1p5b;
  logic [11:0] w_out;

  jtframe_cen24 dut (
    .clk(clk), .rst(rst),
    .cen12(cen12), .cen8(cen8), .cen6(cen6), .cen4(cen4),
    .cen3(cen3), .cen3q(cen3q), .cen1p5(cen1p5),
    .cen12b(cen12b), .cen6b(cen6b), .cen3b(cen3b),
    .cen3qb(cen3qb), .cen1p5b(cen1p5b)
  );

  assign w_out = {cen12, cen8, cen6, cen4, cen3, cen3q, cen1p5,
                  cen12b, cen6b, cen3b, cen3qb, cen1p5b};

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected output vector after an edge with phase kk (or in reset).
  function automatic logic [11:0] model(input bit r, input int kk);
    logic [11:0] v;
    v = '0;
    if (!r) begin
      v[11] = (kk % 2 == 1);
      v[10] = (kk % 3 == 2);
      v[9]  = (kk % 4 == 3);
      v[8]  = (kk % 6 == 5);
      v[7]  = (kk % 8 == 7);
      v[6]  = (kk % 8 == 5);
      v[5]  = (kk % 16 == 15);
`ifdef JTFRAME_CEN24_SHIFTED_EN
      v[4]  = (kk % 2 == 0);
      v[3]  = (kk % 4 == 1);
      v[2]  = (kk % 8 == 3);
      v[1]  = (kk % 8 == 1);
      v[0]  = (kk % 16 == 7);
`endif
    end
    return v;
  endfunction

  // driver: one clk edge with the given reset level, then score the outputs
  task automatic step(input bit r, output logic [11:0] obs);
    rst = r;
    exp_q.push_back(model(r, k));
    @(posedge clk);
    #1;
    obs = w_out;
    check($sformatf("outs rst=%0d k=%0d", r, k), {20'd0, obs}, {20'd0, exp_q.pop_front()});
    if (r) k = 0;
    else k++;
  endtask

  initial begin
    logic [11:0] o;
    int n12, n8, n4, n6, n3, n3q, n1p5;
    n12 = 0; n8 = 0; n4 = 0; n6 = 0; n3 = 0; n3q = 0; n1p5 = 0;

    for (int i = 0; i < 3; i++) step(1'b1, o);

    for (int i = 0; i < 48; i++) begin
      step(1'b0, o);
      n12 += int'(o[11]); n8 += int'(o[10]); n6 += int'(o[9]); n4 += int'(o[8]);
      n3 += int'(o[7]); n3q += int'(o[6]); n1p5 += int'(o[5]);
    end
    check("cnt_cen12", n12, 24);
    check("cnt_cen8", n8, 16);
    check("cnt_cen6", n6, 12);
    check("cnt_cen4", n4, 8);
    check("cnt_cen3", n3, 6);
    check("cnt_cen3q", n3q, 6);
    check("cnt_cen1p5", n1p5, 3);

    // mid-run reset at k=10
    step(1'b1, o);
    for (int i = 0; i < 10; i++) step(1'b0, o);
    step(1'b1, o);
    check("rst_clear", {20'd0, o}, 32'd0);
    for (int i = 0; i < 24; i++) step(1'b0, o);

    // long randomized run with occasional resets
    for (int i = 0; i < 1000; i++) step($urandom_range(0, 63) == 0, o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
